fir_tap_sequencer: RTL

Serial-FIR front end for one equalizer band: it accepts audio samples at the sample-rate strobe and stores them in a circular history of NUMBER_OF_TAPS samples. For each new sample it replays the history newest-first, one tap per clock, together with the matching coefficient index. It drives the band's multiply-accumulate stage (sample, phase_min, clk_enable) and the coefficient lookup (coeff_addr).

---
 rtl/fir_tap_sequencer_pkg.sv | 14 +
 rtl/fir_tap_sequencer_if.sv | 30 +++
 rtl/fir_tap_sequencer_sample_ring_buffer.sv | 35 +++
 rtl/fir_tap_sequencer.sv | 117 +++++++++++
 4 files changed

// File: rtl/fir_tap_sequencer_pkg.sv
// Shared types for the equalizer-band FIR front end: sequencer state and
// tap-index width derivation reused by every band instance.
package fir_tap_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  function automatic int addr_bits(input int number_of_taps);
    return $clog2(number_of_taps);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample input and tap-stream outputs of one FIR band front end.
// master = sample source / MAC side, slave = the sequencer.
interface fir_tap_sequencer_if
  import fir_tap_sequencer_pkg::*;
#(
  parameter int FILTER_IN_BITS = 16,
  parameter int NUMBER_OF_TAPS = 64
);
  localparam int ADDR_BITS = addr_bits(NUMBER_OF_TAPS);

  logic                             sample_valid;
  logic signed [FILTER_IN_BITS-1:0] sample_in;
  logic signed [FILTER_IN_BITS-1:0] delay_filter_in;
  logic        [ADDR_BITS-1:0]      coeff_addr;
  logic                             phase_min;
  logic                             clk_enable;
  logic                             busy;
  logic                             overrun;

  modport master (
    output sample_valid, sample_in,
    input  delay_filter_in, coeff_addr, phase_min, clk_enable, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in,
    output delay_filter_in, coeff_addr, phase_min, clk_enable, busy, overrun
  );

endinterface

// File: rtl/fir_tap_sequencer_sample_ring_buffer.sv
// Circular sample history with one registered write port (at wr_ptr or wr_ptr+1)
// and a combinational read port, so a same-cycle read of the written slot sees old data.
module sample_ring_buffer #(
  parameter int FILTER_IN_BITS = 16,
  parameter int NUMBER_OF_TAPS = 64,
  parameter int ADDR_BITS      = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic                             wr_next,
  input  logic                             ptr_inc,
  input  logic signed [FILTER_IN_BITS-1:0] wr_data,
  output logic        [ADDR_BITS-1:0]      wr_ptr,
  input  logic        [ADDR_BITS-1:0]      rd_ptr,
  output logic signed [FILTER_IN_BITS-1:0] rd_data
);

  logic signed [FILTER_IN_BITS-1:0] hist [NUMBER_OF_TAPS];
  logic        [ADDR_BITS-1:0]      wr_addr;

  assign wr_addr = wr_next ? wr_ptr + ADDR_BITS'(1) : wr_ptr;
  assign rd_data = hist[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUMBER_OF_TAPS; i++) hist[i] <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) hist[wr_addr] <= wr_data;
      if (ptr_inc) wr_ptr <= wr_ptr + ADDR_BITS'(1);
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Replays the sample history newest-first, one tap per clock, for a serial FIR MAC.
// A sample arriving mid-pass is held in a one-entry pending slot; a second one is dropped.
module fir_tap_sequencer
  import fir_tap_sequencer_pkg::*;
#(
  parameter int FILTER_IN_BITS = 16,
  parameter int NUMBER_OF_TAPS = 64
) (
  input  logic                clk,
  input  logic                rst,
  fir_tap_sequencer_if.slave  bus
);

  localparam int ADDR_BITS = addr_bits(NUMBER_OF_TAPS);
  localparam logic [ADDR_BITS-1:0] K_LAST = ADDR_BITS'(NUMBER_OF_TAPS - 1);

  seq_state_t                       state, state_nxt;
  logic        [ADDR_BITS-1:0]      rd_ptr;
  logic        [ADDR_BITS-1:0]      k;
  logic        [ADDR_BITS-1:0]      wr_ptr;
  logic                             pend_valid;
  logic signed [FILTER_IN_BITS-1:0] pend_data;
  logic signed [FILTER_IN_BITS-1:0] rd_data;
  logic signed [FILTER_IN_BITS-1:0] wr_data;
  logic                             overrun_q;
  logic                             last;
  logic                             wr_en, wr_next, ptr_inc;
  logic                             run;

  assign last = (state == RUN) && (k == K_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (bus.sample_valid) state_nxt = RUN;
    end else if (last && !pend_valid && !bus.sample_valid) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    run     = (state == RUN);
    wr_en   = 1'b0;
    wr_next = run;
    ptr_inc = last;
    wr_data = bus.sample_in;
    if (!run) wr_en = bus.sample_valid;
    else if (last) begin
      wr_en = pend_valid || bus.sample_valid;
      if (pend_valid) wr_data = pend_data;
    end
  end

  // When idle after a pass, rd_ptr and k are frozen so the tap outputs hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      k          <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overrun_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.sample_valid) begin
        rd_ptr <= wr_ptr;
        k      <= '0;
      end
    end else if (!last) begin
      rd_ptr <= rd_ptr - ADDR_BITS'(1);
      k      <= k + ADDR_BITS'(1);
      if (bus.sample_valid) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_data  <= bus.sample_in;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end else begin
      if (pend_valid || bus.sample_valid) begin
        rd_ptr <= wr_ptr + ADDR_BITS'(1);
        k      <= '0;
      end
      // Pending slot frees this cycle, so a coincident strobe can refill it.
      pend_valid <= pend_valid && bus.sample_valid;
      if (pend_valid && bus.sample_valid) pend_data <= bus.sample_in;
    end
  end

  sample_ring_buffer #(
    .FILTER_IN_BITS (FILTER_IN_BITS),
    .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
    .ADDR_BITS      (ADDR_BITS)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_next (wr_next),
    .ptr_inc (ptr_inc),
    .wr_data (wr_data),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.delay_filter_in = rd_data;
  assign bus.coeff_addr      = k;
  assign bus.phase_min       = run && (k == '0);
  assign bus.clk_enable      = run;
  assign bus.busy            = run;
  assign bus.overrun         = overrun_q;

endmodule
